position_cache_nb_serializer_half_shell: RTL and testbench

Registered, time-multiplexed successor to the combinational half-shell position-cache-to-PE mapping. It captures one readout from every cell's position cache and streams each cell's home position plus its 13 half-shell neighbours to the PEs. The stream runs over `NUM_LANES` neighbour slots per beat, with valid/ready backpressure. Per-axis periodic/open boundary control yields a per-lane neighbour-valid mask. The block sits between the position caches and the PE filter inputs, and lets the PE fan-in width trade against throughput.

---
 rtl/position_cache_nb_serializer_half_shell.sv | 161 ++++++++++++++++
 tb/tb_position_cache_nb_serializer_half_shell.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/position_cache_nb_serializer_half_shell.sv
// Captures one readout of every cell's position cache and streams each cell's home
// position plus its 13 half-shell neighbours to the PEs, NUM_LANES slots per beat.
module position_cache_nb_serializer_half_shell #(
    parameter int X_DIM              = 4,
    parameter int Y_DIM              = 4,
    parameter int Z_DIM              = 4,
    parameter int NUM_CELLS          = X_DIM*Y_DIM*Z_DIM,
    parameter int OFFSET_WIDTH       = 29,
    parameter int POS_CACHE_WIDTH    = 3*OFFSET_WIDTH,
    parameter int NUM_NEIGHBOR_CELLS = 13,
    parameter int NUM_LANES          = 4
) (
    input  logic                                                  clk,
    input  logic                                                  rst_n,
    input  logic                                                  in_valid,
    output logic                                                  in_ready,
    input  logic [2:0]                                            cfg_periodic,
    input  logic [NUM_CELLS-1:0][POS_CACHE_WIDTH-1:0]             rd_nb_position,
    output logic                                                  out_valid,
    input  logic                                                  out_ready,
    output logic [NUM_CELLS-1:0][NUM_LANES-1:0][POS_CACHE_WIDTH-1:0] out_data,
    output logic [NUM_CELLS-1:0][NUM_LANES-1:0]                   out_nb_valid,
    output logic [3:0]                                            out_slot_base,
    output logic                                                  out_last
);

    localparam int NUM_SLOTS = NUM_NEIGHBOR_CELLS + 1;
    localparam int NUM_BEATS = (NUM_SLOTS + NUM_LANES - 1) / NUM_LANES;
    localparam int LAST_BEAT = NUM_BEATS - 1;

    typedef enum logic {IDLE, EMIT} state_t;

    state_t                                      state;
    logic [3:0]                                  beat;
    logic [NUM_CELLS-1:0][POS_CACHE_WIDTH-1:0]   snap;
    logic [2:0]                                  snap_cfg;

    logic                                        capture;
    logic [3:0]                                  sel_beat;
    logic [NUM_CELLS-1:0][POS_CACHE_WIDTH-1:0]   src_words;
    logic [2:0]                                  src_cfg;
    logic [NUM_CELLS-1:0][NUM_SLOTS-1:0][POS_CACHE_WIDTH-1:0] slot_word;
    logic [NUM_CELLS-1:0][NUM_SLOTS-1:0]         slot_ok;
    logic [NUM_CELLS-1:0][NUM_LANES-1:0][POS_CACHE_WIDTH-1:0] next_data;
    logic [NUM_CELLS-1:0][NUM_LANES-1:0]         next_nbv;
    int                                          slot_idx;

    function automatic int slot_dx(int s);
        case (s)
            1, 4, 7, 10, 13: return 1;
            2, 5, 8, 11:     return -1;
            default:         return 0;
        endcase
    endfunction

    function automatic int slot_dy(int s);
        case (s)
            2, 3, 4, 11, 12, 13: return 1;
            5, 6, 7:             return -1;
            default:             return 0;
        endcase
    endfunction

    function automatic int slot_dz(int s);
        return (s >= 5) ? 1 : 0;
    endfunction

    function automatic int wrap(int v, int dim);
        return (v + dim) % dim;
    endfunction

    function automatic int nb_cell(int c, int s);
        int x, y, z;
        x = c % X_DIM;
        y = (c / X_DIM) % Y_DIM;
        z = c / (X_DIM * Y_DIM);
        return wrap(z + slot_dz(s), Z_DIM) * X_DIM * Y_DIM
             + wrap(y + slot_dy(s), Y_DIM) * X_DIM
             + wrap(x + slot_dx(s), X_DIM);
    endfunction

    function automatic logic [2:0] nb_cross(int c, int s);
        int ux, uy, uz;
        ux = c % X_DIM + slot_dx(s);
        uy = (c / X_DIM) % Y_DIM + slot_dy(s);
        uz = c / (X_DIM * Y_DIM) + slot_dz(s);
        return {(uz < 0) || (uz >= Z_DIM),
                (uy < 0) || (uy >= Y_DIM),
                (ux < 0) || (ux >= X_DIM)};
    endfunction

    assign in_ready = (state == IDLE) | ((state == EMIT) & out_last & out_ready);
    assign capture  = in_valid & in_ready;

    // A fresh capture always starts at beat 0 straight from the readout; otherwise
    // the snapshot feeds the following beat, so the output registers never see a stale mux.
    assign src_words = capture ? rd_nb_position : snap;
    assign src_cfg   = capture ? cfg_periodic : snap_cfg;
    assign sel_beat  = capture ? 4'd0 : beat + 4'd1;

    for (genvar c = 0; c < NUM_CELLS; c++) begin : g_cell
        for (genvar s = 0; s < NUM_SLOTS; s++) begin : g_slot
            localparam int         NB_IDX   = nb_cell(c, s);
            localparam logic [2:0] NB_CROSS = nb_cross(c, s);
            assign slot_word[c][s] = src_words[NB_IDX];
            assign slot_ok[c][s]   = ((NB_CROSS & ~src_cfg) == 3'b000);
        end
    end

    always_comb begin
        next_data = '0;
        next_nbv  = '0;
        slot_idx  = 0;
        for (int c = 0; c < NUM_CELLS; c++) begin
            for (int l = 0; l < NUM_LANES; l++) begin
                slot_idx = int'(sel_beat) * NUM_LANES + l;
                if (slot_idx < NUM_SLOTS) begin
                    next_data[c][l] = slot_word[c][slot_idx[3:0]];
                    next_nbv[c][l]  = slot_ok[c][slot_idx[3:0]];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            beat          <= '0;
            snap          <= '0;
            snap_cfg      <= '0;
            out_valid     <= 1'b0;
            out_last      <= 1'b0;
            out_slot_base <= '0;
            out_data      <= '0;
            out_nb_valid  <= '0;
        end else if (capture) begin
            state         <= EMIT;
            beat          <= '0;
            snap          <= rd_nb_position;
            snap_cfg      <= cfg_periodic;
            out_valid     <= 1'b1;
            out_last      <= (LAST_BEAT == 0);
            out_slot_base <= '0;
            out_data      <= next_data;
            out_nb_valid  <= next_nbv;
        end else if (state == EMIT && out_ready) begin
            if (beat == 4'(LAST_BEAT)) begin
                state     <= IDLE;
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end else begin
                beat          <= beat + 4'd1;
                out_last      <= (beat == 4'(LAST_BEAT - 1));
                out_slot_base <= out_slot_base + 4'(NUM_LANES);
                out_data      <= next_data;
                out_nb_valid  <= next_nbv;
            end
        end
    end

endmodule

// File: tb/tb_position_cache_nb_serializer_half_shell.sv
// Directed and randomized checks of the half-shell serializer in 4-, 1- and 14-lane
// builds against a coordinate-level model of the neighbour mapping.
module tb_position_cache_nb_serializer_half_shell;

    localparam int W     = 87;
    localparam int NC    = 64;
    localparam int NS    = 14;
    localparam int DMAX  = NC * NS * W;
    localparam int NBMAX = NC * NS;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic                   in_valid;
    logic                   out_ready;
    logic [2:0]             cfg_periodic;
    logic [NC-1:0][W-1:0]   rd;

    logic                   ir4, ov4, ol4;
    logic [3:0]             sb4;
    logic [NC-1:0][3:0][W-1:0] d4;
    logic [NC-1:0][3:0]     v4;
    logic                   ir1, ov1, ol1;
    logic [3:0]             sb1;
    logic [NC-1:0][0:0][W-1:0] d1;
    logic [NC-1:0][0:0]     v1;
    logic                   ir14, ov14, ol14;
    logic [3:0]             sb14;
    logic [NC-1:0][13:0][W-1:0] d14;
    logic [NC-1:0][13:0]    v14;

    position_cache_nb_serializer_half_shell u_l4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir4),
        .cfg_periodic(cfg_periodic), .rd_nb_position(rd), .out_valid(ov4),
        .out_ready(out_ready), .out_data(d4), .out_nb_valid(v4),
        .out_slot_base(sb4), .out_last(ol4));

    position_cache_nb_serializer_half_shell #(.NUM_LANES(1)) u_l1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir1),
        .cfg_periodic(cfg_periodic), .rd_nb_position(rd), .out_valid(ov1),
        .out_ready(out_ready), .out_data(d1), .out_nb_valid(v1),
        .out_slot_base(sb1), .out_last(ol1));

    position_cache_nb_serializer_half_shell #(.NUM_LANES(14)) u_l14 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir14),
        .cfg_periodic(cfg_periodic), .rd_nb_position(rd), .out_valid(ov14),
        .out_ready(out_ready), .out_data(d14), .out_nb_valid(v14),
        .out_slot_base(sb14), .out_last(ol14));

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int spot_mode = 0;

    logic [W-1:0] m_words [NC];
    logic [2:0]   m_cfg;
    logic [W-1:0] n_words [NC];
    logic [2:0]   n_cfg;

    int dxs [NS] = '{0, 1, -1, 0, 1, -1, 0, 1, -1, 0, 1, -1, 0, 1};
    int dys [NS] = '{0, 0, 1, 1, 1, -1, -1, -1, 0, 0, 0, 1, 1, 1};
    int dzs [NS] = '{0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1, 1, 1, 1};

    // Reference: walk to the neighbour in 3-D coordinates, wrap for the data word,
    // and mark the lane invalid if an open axis was stepped across.
    function automatic void model(input int c, input int s, output logic [W-1:0] w, output logic v);
        int ux, uy, uz;
        bit ox, oy, oz;
        ux = c % 4 + dxs[s];
        uy = (c / 4) % 4 + dys[s];
        uz = c / 16 + dzs[s];
        ox = (ux < 0) || (ux > 3);
        oy = (uy < 0) || (uy > 3);
        oz = (uz < 0) || (uz > 3);
        w = m_words[((uz + 4) % 4) * 16 + ((uy + 4) % 4) * 4 + (ux + 4) % 4];
        v = !((ox && !m_cfg[0]) || (oy && !m_cfg[1]) || (oz && !m_cfg[2]));
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_beat(input string name, input int lanes, input int beat,
                              input logic [DMAX-1:0] data, input logic [NBMAX-1:0] nbv,
                              input logic [3:0] base, input logic last, input logic valid);
        int nbeats, mism, fc, fl, s;
        logic [W-1:0] ew, gw, few, fgw;
        logic ev, gv, fev, fgv;
        nbeats = (NS + lanes - 1) / lanes;
        mism = 0; fc = 0; fl = 0; few = '0; fgw = '0; fev = 1'b0; fgv = 1'b0;
        for (int c = 0; c < NC; c++) begin
            for (int l = 0; l < lanes; l++) begin
                s = beat * lanes + l;
                if (s < NS) model(c, s, ew, ev);
                else begin ew = '0; ev = 1'b0; end
                gw = data[(c * lanes + l) * W +: W];
                gv = nbv[c * lanes + l];
                if (gw !== ew || gv !== ev) begin
                    if (mism == 0) begin fc = c; fl = l; few = ew; fgw = gw; fev = ev; fgv = gv; end
                    mism++;
                end
            end
        end
        n_checks++;
        assert (mism === 0)
        else begin
            n_fail++;
            $error("[TB] FAIL %s beat%0d data: %0d lanes differ, first cell %0d lane %0d observed %h/%b expected %h/%b",
                   name, beat, mism, fc, fl, fgw, fgv, few, fev);
        end
        check($sformatf("%s beat%0d slot_base", name, beat), 64'(base), 64'(beat * lanes));
        check($sformatf("%s beat%0d last", name, beat), 64'(last), 64'(beat == nbeats - 1));
        check($sformatf("%s beat%0d valid", name, beat), 64'(valid), 64'd1);
    endtask

    task automatic chk4(input int b);
        check_beat("L4", 4, b, DMAX'(d4), NBMAX'(v4), sb4, ol4, ov4);
    endtask

    task automatic chk1(input int b);
        check_beat("L1", 1, b, DMAX'(d1), NBMAX'(v1), sb1, ol1, ov1);
    endtask

    task automatic chk14(input int b);
        check_beat("L14", 14, b, DMAX'(d14), NBMAX'(v14), sb14, ol14, ov14);
    endtask

    task automatic spot_checks(input int b);
        if (spot_mode == 1) begin
            if (b == 0) begin
                check("c3 s1 data", 64'(d4[3][1]), 64'd0);
                check("c3 s1 nbv", 64'(v4[3][1]), 64'd1);
            end
            if (b == 1) check("c0 s5 data", 64'(d4[0][1]), 64'd31);
            if (b == 3) begin
                check("c63 s13 data", 64'(d4[63][1]), 64'd0);
                check("pad nbv c0", 64'(v4[0][3:2]), 64'd0);
                check("pad data c63 l3", 64'(d4[63][3] != '0), 64'd0);
            end
        end else if (spot_mode == 2) begin
            if (b == 0) begin
                check("open c3 s1 nbv", 64'(v4[3][1]), 64'd0);
                check("open c0 s2 nbv", 64'(v4[0][2]), 64'd0);
            end
            if (b == 2) begin
                check("open c3 s9 data", 64'(d4[3][1]), 64'd19);
                check("open c3 s9 nbv", 64'(v4[3][1]), 64'd1);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic gen_next();
        for (int c = 0; c < NC; c++) n_words[c] = W'({$urandom, $urandom, $urandom});
        n_cfg = 3'($urandom);
    endtask

    task automatic garbage();
        for (int c = 0; c < NC; c++) rd[c] = W'({$urandom, $urandom, $urandom});
        cfg_periodic = 3'($urandom);
    endtask

    task automatic applyStimulus();
        for (int c = 0; c < NC; c++) rd[c] = n_words[c];
        cfg_periodic = n_cfg;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1;
        check("in_ready idle", 64'(ir4), 64'd1);
        tick();
        in_valid = 1'b0;
        garbage();
        for (int c = 0; c < NC; c++) m_words[c] = n_words[c];
        m_cfg = n_cfg;
    endtask

    task automatic checkOutput(input int stall_beat, input int stall_len, input bit chain);
        bit stalled;
        for (int b = 0; b < 4; b++) begin
            for (int s = 0; s <= ((b == stall_beat) ? stall_len : 0); s++) begin
                stalled   = (b == stall_beat) && (s < stall_len);
                out_ready = !stalled;
                if (chain) begin
                    for (int c = 0; c < NC; c++) rd[c] = n_words[c];
                    cfg_periodic = n_cfg;
                    in_valid = 1'b1;
                end
                #1;
                check($sformatf("in_ready beat%0d", b), 64'(ir4), 64'(!stalled && b == 3));
                chk4(b);
                spot_checks(b);
                tick();
            end
        end
        out_ready = 1'b1;
        if (chain) begin
            in_valid = 1'b0;
            for (int c = 0; c < NC; c++) m_words[c] = n_words[c];
            m_cfg = n_cfg;
            garbage();
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, " out_valid"}, 64'(ov4), 64'd0);
        check({tag, " in_ready"}, 64'(ir4), 64'd1);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        cfg_periodic = '0; rd = '0;
        #12;
        check("rst out_valid", 64'(ov4), 64'd0);
        check("rst out_last", 64'(ol4), 64'd0);
        check("rst slot_base", 64'(sb4), 64'd0);
        check("rst data nonzero", 64'(d4 != '0), 64'd0);
        check("rst nbv", 64'(v4), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Ramp pattern, fully periodic
        for (int c = 0; c < NC; c++) n_words[c] = W'(c);
        n_cfg = 3'b111;
        spot_mode = 1;
        applyStimulus();
        checkOutput(-1, 0, 1'b0);
        check_idle("after periodic");

        // Ramp pattern, open x axis
        n_cfg = 3'b110;
        spot_mode = 2;
        applyStimulus();
        checkOutput(-1, 0, 1'b0);
        check_idle("after open-x");
        spot_mode = 0;

        // Three-cycle stall on beat 1
        gen_next();
        applyStimulus();
        checkOutput(1, 3, 1'b0);
        check_idle("after stall");

        // Back-to-back captures with in_valid held high
        gen_next();
        applyStimulus();
        gen_next();
        checkOutput(-1, 0, 1'b1);
        checkOutput(-1, 0, 1'b0);
        check_idle("after chain");

        // Random data, boundaries and stalls
        for (int i = 0; i < 4; i++) begin
            gen_next();
            applyStimulus();
            checkOutput(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'b0);
            check_idle($sformatf("after random %0d", i));
        end

        // Reset asserted while beat 2 is on the outputs
        gen_next();
        applyStimulus();
        chk4(0); tick();
        chk4(1); tick();
        chk4(2);
        rst_n = 1'b0;
        #1;
        check("midrst out_valid", 64'(ov4), 64'd0);
        check("midrst slot_base", 64'(sb4), 64'd0);
        check("midrst data nonzero", 64'(d4 != '0), 64'd0);
        check("midrst nbv", 64'(v4), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("post-rst idle %0d", i), 64'(ov4), 64'd0);
        end

        // All three lane widths stream one capture side by side
        gen_next();
        applyStimulus();
        for (int k = 0; k < NS; k++) begin
            chk1(k);
            if (k < 4) chk4(k);
            if (k == 0) chk14(0);
            tick();
        end
        check("L1 done out_valid", 64'(ov1), 64'd0);
        check("L14 done out_valid", 64'(ov14), 64'd0);
        check("L4 done out_valid", 64'(ov4), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
